// File: rtl/tdm_mux_4_to_1_if.sv
// tdm_mux_4_to_1_if: channel inputs and multiplexed slot outputs of the 4-to-1 TDM mux
interface tdm_mux_4_to_1_if #(parameter int WIDTH = 1);
  logic en;
  logic [3:0] chan_mask;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] out;
  logic [1:0] sel;
  logic valid;
  logic frame_start;
  modport master (
    output en, chan_mask, in0, in1, in2, in3,
    input out, sel, valid, frame_start
  );
  modport slave (
    input en, chan_mask, in0, in1, in2, in3,
    output out, sel, valid, frame_start
  );
endinterface

// File: rtl/tdm_mux_4_to_1.sv
// tdm_mux_4_to_1: round-robin serialiser of four channels with demux control index and frame marker
module tdm_mux_4_to_1 #(
  parameter int WIDTH = 1,
  parameter int SLOT_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  tdm_mux_4_to_1_if.slave bus
);
  localparam int CW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] first;
  logic [1:0] nxt;
  logic [WIDTH-1:0] ins [4];
  assign ins = '{bus.in0, bus.in1, bus.in2, bus.in3};
  // lowest enabled channel starts a run; next enabled channel after sel (wrapping, sel itself last) continues it
  always_comb begin
    first = bus.chan_mask[0] ? 2'd0 : bus.chan_mask[1] ? 2'd1 : bus.chan_mask[2] ? 2'd2 : 2'd3;
    nxt = bus.sel;
    for (int i = 4; i >= 1; i--)
      if (bus.chan_mask[bus.sel + 2'(i)]) nxt = bus.sel + 2'(i);
  end
  // slot sequencer: inputs are sampled only on the edge that opens a slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.out <= '0;
      bus.sel <= '0;
      bus.valid <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      if (state == IDLE) begin
        if (bus.en && |bus.chan_mask) begin
          state <= RUN;
          cnt <= '0;
          bus.out <= ins[first];
          bus.sel <= first;
          bus.valid <= 1'b1;
          bus.frame_start <= 1'b1;
        end
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end else if (!bus.en || bus.chan_mask == 4'd0) begin
        state <= IDLE;
        cnt <= '0;
        bus.out <= '0;
        bus.sel <= '0;
        bus.valid <= 1'b0;
      end else begin
        cnt <= '0;
        bus.out <= ins[nxt];
        bus.sel <= nxt;
        bus.frame_start <= (nxt <= bus.sel);
      end
    end
  end
endmodule

// File: tb/tb_tdm_mux_4_to_1.sv
// tb_tdm_mux_4_to_1: directed checks of slot timing, masking, stop, reset and demux loopback
module tb_tdm_mux_4_to_1;
  logic clk = 1'b0;
  logic rst_n;
  int pass_cnt = 0;
  int total = 0;
  tdm_mux_4_to_1_if #(.WIDTH(1)) b();
  tdm_mux_4_to_1_if #(.WIDTH(1)) b1();
  tdm_mux_4_to_1 #(.WIDTH(1), .SLOT_CYCLES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b));
  tdm_mux_4_to_1 #(.WIDTH(1), .SLOT_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic [3:0] dm;
  always #5 clk = ~clk;
  // downstream 1-to-4 demux driven by sel/out
  always_comb begin
    dm = 4'd0;
    dm[b.sel] = b.out;
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [4:0] act;
    rst_n = 1'b0;
    b.en = 1'b1; b.chan_mask = 4'b1111;
    b.in0 = 1'b1; b.in1 = 1'b0; b.in2 = 1'b1; b.in3 = 1'b0;
    b1.en = 1'b0; b1.chan_mask = 4'b0000;
    b1.in0 = 1'b0; b1.in1 = 1'b0; b1.in2 = 1'b0; b1.in3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      act = {b.out, b.sel, b.valid, b.frame_start};
      total++;
      if (act !== 5'd0) $display("FAIL reset k=%0d {out,sel,valid,fs} got %b want 00000", k, act);
      else pass_cnt++;
    end
  endtask
  task automatic test_rotation;
    logic [1:0] s;
    logic [4:0] act, exp;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      s = 2'((k / 4) % 4);
      exp = {~s[0], s, 1'b1, k % 16 == 0};
      act = {b.out, b.sel, b.valid, b.frame_start};
      total++;
      if (act !== exp) $display("FAIL rotation k=%0d {out,sel,valid,fs} got %b want %b", k, act, exp);
      else pass_cnt++;
    end
  endtask
  task automatic test_masked_skip;
    logic [1:0] s;
    logic [4:0] act, exp;
    rst_n = 1'b0;
    b.chan_mask = 4'b1010; b.in1 = 1'b1; b.in3 = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      s = (k / 4) % 2 == 1 ? 2'd3 : 2'd1;
      exp = {s == 2'd1, s, 1'b1, k % 8 == 0};
      act = {b.out, b.sel, b.valid, b.frame_start};
      total++;
      if (act !== exp) $display("FAIL masked k=%0d {out,sel,valid,fs} got %b want %b", k, act, exp);
      else pass_cnt++;
    end
  endtask
  task automatic test_hold_late_change;
    logic [1:0] s;
    logic [4:0] act, exp;
    rst_n = 1'b0;
    b.chan_mask = 4'b1111;
    b.in0 = 1'b1; b.in1 = 1'b0; b.in2 = 1'b1; b.in3 = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      s = 2'(k / 4);
      exp = k == 12 ? {1'b1, 2'd0, 1'b1, 1'b1} : {~s[0], s, 1'b1, k == 0};
      act = {b.out, b.sel, b.valid, b.frame_start};
      total++;
      if (act !== exp) $display("FAIL hold k=%0d {out,sel,valid,fs} got %b want %b", k, act, exp);
      else pass_cnt++;
      if (k == 9) begin
        b.in2 = 1'b0;
        b.chan_mask = 4'b0111;
      end
    end
  endtask
  task automatic test_stop;
    logic [4:0] act, exp;
    for (int k = 13; k < 18; k++) begin
      step();
      exp = k < 16 ? {1'b1, 2'd0, 1'b1, 1'b0} : 5'd0;
      act = {b.out, b.sel, b.valid, b.frame_start};
      total++;
      if (act !== exp) $display("FAIL stop k=%0d {out,sel,valid,fs} got %b want %b", k, act, exp);
      else pass_cnt++;
      if (k == 13) b.en = 1'b0;
    end
  endtask
  task automatic test_single_channel;
    logic [4:0] act, exp;
    rst_n = 1'b0;
    b.en = 1'b1; b.chan_mask = 4'b0100; b.in2 = 1'b1;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      exp = {1'b1, 2'd2, 1'b1, k % 4 == 0};
      act = {b.out, b.sel, b.valid, b.frame_start};
      total++;
      if (act !== exp) $display("FAIL single k=%0d {out,sel,valid,fs} got %b want %b", k, act, exp);
      else pass_cnt++;
    end
  endtask
  task automatic test_reset_mid_slot;
    logic [4:0] act;
    step();
    step();
    rst_n = 1'b0;
    step();
    act = {b.out, b.sel, b.valid, b.frame_start};
    total++;
    if (act !== 5'd0) $display("FAIL reset_mid {out,sel,valid,fs} got %b want 00000", act);
    else pass_cnt++;
  endtask
  task automatic test_loopback;
    logic [3:0] tab, exp;
    logic [1:0] s;
    tab = 4'b0110;
    rst_n = 1'b0;
    b.en = 1'b1; b.chan_mask = 4'b1111;
    b.in0 = tab[0]; b.in1 = tab[1]; b.in2 = tab[2]; b.in3 = tab[3];
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      s = 2'(k / 4);
      exp = 4'd0;
      exp[s] = tab[s];
      total++;
      if (dm !== exp || b.sel !== s) $display("FAIL loopback k=%0d demux/sel got %b/%0d want %b/%0d", k, dm, b.sel, exp, s);
      else pass_cnt++;
    end
  endtask
  task automatic test_slot1;
    logic [3:0] tab;
    logic [1:0] s;
    logic [3:0] act, exp;
    tab = 4'b0011;
    rst_n = 1'b0;
    b1.en = 1'b1; b1.chan_mask = 4'b1111;
    b1.in0 = tab[0]; b1.in1 = tab[1]; b1.in2 = tab[2]; b1.in3 = tab[3];
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      s = 2'(k % 4);
      exp = {tab[s], s, k % 4 == 0};
      act = {b1.out, b1.sel, b1.frame_start};
      total++;
      if (act !== exp || b1.valid !== 1'b1) $display("FAIL slot1 k=%0d {out,sel,fs}/valid got %b/%b want %b/1", k, act, b1.valid, exp);
      else pass_cnt++;
    end
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_masked_skip();
    test_hold_late_change();
    test_stop();
    test_single_channel();
    test_reset_mid_slot();
    test_loopback();
    test_slot1();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/tdm_mux_4_to_1.md
Name: tdm_mux_4_to_1

Overview:
Time-division multiplexer that serialises four input channels onto one output line, round-robin. It drives the 2-bit channel index alongside the data so a downstream DEMUX_1_to_4 can use it as `control` and redistribute the samples. It is the transmit end of the 1-to-4 demux path in the lab datapath.

Parameters:
WIDTH, 1, data width of each channel and of `out`.
SLOT_CYCLES, 4, clock cycles each channel slot is held on `out`. Must be ≥1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  synchronous reset, active-low.
en  input  1  run enable.
chan_mask  input  4  per-channel enable; bit i = channel i.
in0  input  WIDTH  channel 0 data.
in1  input  WIDTH  channel 1 data.
in2  input  WIDTH  channel 2 data.
in3  input  WIDTH  channel 3 data.
out  output  WIDTH  registered multiplexed data.
sel  output  2  index of the channel currently on `out` (demux control).
valid  output  1  high while `out` and `sel` carry a live slot.
frame_start  output  1  1-cycle pulse on the first cycle of each frame.

Behaviour:
- Reset:
  - rst_n=0 sampled at a clk edge forces out=0, sel=0, valid=0, frame_start=0, slot counter=0, state=IDLE.
  - Reset asserted mid-slot aborts the slot at that edge; no partial-slot completion.
- State machine:
  - IDLE: leave when en=1 and chan_mask≠0 → RUN. On that edge, load the lowest-index enabled channel: out←in[k], sel←k, valid←1, frame_start←1, counter←0.
  - RUN: counter increments each cycle. Data, sel and valid hold steady for exactly SLOT_CYCLES cycles.
- Slot boundary (counter==SLOT_CYCLES-1):
  - If en=0 or chan_mask==0: go to IDLE next edge; valid←0, out←0, sel←0.
  - Otherwise advance to the next enabled channel after sel, in ascending order with wrap 3→0; skip masked channels. Sample that input into out, set sel, counter←0.
  - frame_start←1 only when the new channel index ≤ the old one (wrap), or when only one channel is enabled (every slot is a frame).
- Sampling: input data is captured only at slot start (the registered edge). Changes mid-slot are not reflected on out.
- Latency: en=1 sampled at edge N → first valid slot visible after edge N, i.e. during cycle N+1.
- Mid-operation changes to en or chan_mask take effect only at the next slot boundary. The current slot always completes.
- If the currently selected channel becomes masked mid-slot, the slot still completes, then the next enabled channel is chosen.
- Counter width is $clog2(SLOT_CYCLES), minimum 1 bit. With SLOT_CYCLES=1 the channel changes every cycle.
- frame_start is low in every cycle other than those specified above.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with en=1, mask=4'b1111 → out=0, sel=0, valid=0, frame_start=0 throughout.
2. Full rotation: WIDTH=1, SLOT_CYCLES=4, mask=4'b1111, in0..in3=1,0,1,0, en=1.
   - Expected: sel=0,1,2,3,0 with 4 cycles each; out=1,0,1,0,1; valid=1.
   - frame_start pulses at cycles 1 and 17.
3. Masked skip: mask=4'b1010 → sel alternates 1,3,1,3 every 4 cycles. frame_start pulses on each sel=1 slot start.
4. Hold/late change: change in2 from 1 to 0 two cycles into sel=2 → out stays 1 until the slot ends. Clear mask bit 3 mid-slot 2 → next sel=0, not 3.
5. Stop and single channel:
   - Drop en mid-slot → slot finishes its 4 cycles, then valid=0, sel=0, out=0.
   - mask=4'b0100 → sel=2 every slot, frame_start pulses every 4 cycles.
6. Reset mid-slot plus loopback: assert rst_n=0 at cycle 2 of a slot → all outputs 0 next edge. Also drive DEMUX_1_to_4 with control=sel and in=out (WIDTH=1) → demux out[sel] equals the sampled in[sel] for each slot.
